// File: rtl/paeth_caller.sv
// Host-side initiator that sweeps idx over a range of calls to the paeth component and queues the returns.
// Optional running checksum of accepted returndata: define PAETH_CALLER_CHECKSUM_EN.
module paeth_caller #(
   parameter int IDX_W           = 32,
   parameter int DATA_W          = 32,
   parameter int CNT_W           = 16,
   parameter int FIFO_DEPTH      = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                     clock,
   input  logic                                     resetn,
   input  logic                                     cmd_valid,
   output logic                                     cmd_ready,
   input  logic [IDX_W-1:0]                         cmd_base,
   input  logic [CNT_W-1:0]                         cmd_count,
   output logic                                     comp_start,
   input  logic                                     comp_busy,
   output logic [IDX_W-1:0]                         comp_idx,
   input  logic                                     comp_done,
   output logic                                     comp_stall,
   input  logic [DATA_W-1:0]                        comp_returndata,
   output logic                                     res_valid,
   input  logic                                     res_ready,
   output logic [DATA_W-1:0]                        res_data,
   output logic                                     sweep_done,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
   output logic [DATA_W-1:0]                        checksum,
   output logic                                     err_unexpected
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam logic [OW-1:0] MAX_O  = OW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  remaining, remaining_nxt;
   logic [OW-1:0]     outstanding_nxt;
   logic [CW-1:0]     fifo_cnt, fifo_cnt_nxt;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic cmd_acc, call_acc, ret_acc, push, pop, start_nxt;

   assign cmd_ready  = (state == S_IDLE);
   assign cmd_acc    = cmd_valid && cmd_ready;
   assign call_acc   = comp_start && !comp_busy;
   assign comp_stall = (fifo_cnt == FULL_C);
   assign ret_acc    = comp_done && !comp_stall;
   // A return with nothing in flight is dropped rather than queued.
   assign push       = ret_acc && (outstanding != '0);
   assign res_valid  = (fifo_cnt != '0);
   assign pop        = res_valid && res_ready;
   assign res_data   = mem[rd_ptr];
   assign sweep_done = (state == S_FINISH);

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               remaining_nxt = cmd_count;
               state_nxt     = (cmd_count == '0) ? S_FINISH : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (call_acc) begin
               remaining_nxt = remaining - CNT_W'(1);
               if (remaining == CNT_W'(1)) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (outstanding == '0) state_nxt = S_FINISH;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      outstanding_nxt = outstanding;
      case ({call_acc, push})
         2'b10:   outstanding_nxt = outstanding + OW'(1);
         2'b01:   outstanding_nxt = outstanding - OW'(1);
         default: outstanding_nxt = outstanding;
      endcase
      fifo_cnt_nxt = fifo_cnt;
      case ({push, pop})
         2'b10:   fifo_cnt_nxt = fifo_cnt + CW'(1);
         2'b01:   fifo_cnt_nxt = fifo_cnt - CW'(1);
         default: fifo_cnt_nxt = fifo_cnt;
      endcase
   end

   // Credits are evaluated on next-cycle state so comp_start can stay registered at 1 call/clock.
   // A stalled call is held; returns only lower outstanding+fifo_cnt, so its credit stays valid.
   always_comb begin
      start_nxt = 1'b0;
      if (comp_start && comp_busy) begin
         start_nxt = 1'b1;
      end else if ((state_nxt == S_ISSUE) && (remaining_nxt != '0) &&
                   (outstanding_nxt < MAX_O) &&
                   (int'(outstanding_nxt) + int'(fifo_cnt_nxt) < FIFO_DEPTH)) begin
         start_nxt = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state          <= S_IDLE;
         remaining      <= '0;
         comp_start     <= 1'b0;
         comp_idx       <= '0;
         outstanding    <= '0;
         fifo_cnt       <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         err_unexpected <= 1'b0;
      end else begin
         state       <= state_nxt;
         remaining   <= remaining_nxt;
         comp_start  <= start_nxt;
         outstanding <= outstanding_nxt;
         fifo_cnt    <= fifo_cnt_nxt;
         if (cmd_acc)
            comp_idx <= cmd_base;
         else if (call_acc)
            comp_idx <= comp_idx + IDX_W'(1);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (ret_acc && (outstanding == '0)) err_unexpected <= 1'b1;
      end
   end

   // Result storage carries no reset; validity is tracked by fifo_cnt alone.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= comp_returndata;
   end

`ifdef PAETH_CALLER_CHECKSUM_EN
   function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      return a + b;
   endfunction

   always_ff @(posedge clock) begin
      if (!resetn)
         checksum <= '0;
      else if (cmd_acc)
         checksum <= '0;
      else if (push)
         checksum <= wrap_add(checksum, comp_returndata);
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_paeth_caller.sv
// Directed bench for paeth_caller: table of sweeps against a fixed-latency in-order callee model,
// plus hand-written backpressure, busy-hold, zero-count and reset sequences.
module tb_paeth_caller;

   localparam int IDX_W = 32, DATA_W = 32, CNT_W = 16, FIFO_DEPTH = 8, MAX_OUT = 4;
   localparam int OW = $clog2(MAX_OUT + 1);
`ifdef PAETH_CALLER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              resetn = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [IDX_W-1:0]  cmd_base = '0;
   logic [CNT_W-1:0]  cmd_count = '0;
   logic              comp_start;
   logic              comp_busy = 1'b0;
   logic [IDX_W-1:0]  comp_idx;
   logic              comp_done = 1'b0;
   logic              comp_stall;
   logic [DATA_W-1:0] comp_returndata = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [DATA_W-1:0] res_data;
   logic              sweep_done;
   logic [OW-1:0]     outstanding;
   logic [DATA_W-1:0] checksum;
   logic              err_unexpected;

   paeth_caller #(
      .IDX_W(IDX_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
      .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clock(clock), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_count(cmd_count),
      .comp_start(comp_start), .comp_busy(comp_busy), .comp_idx(comp_idx),
      .comp_done(comp_done), .comp_stall(comp_stall), .comp_returndata(comp_returndata),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .sweep_done(sweep_done), .outstanding(outstanding), .checksum(checksum),
      .err_unexpected(err_unexpected)
   );

   typedef struct {
      logic [31:0] base;
      int          count;
      int          lat;
      int          exp_calls;
      logic [31:0] exp_first_idx;
      logic [31:0] exp_last_idx;
      logic [31:0] exp_first_data;
      logic [31:0] exp_last_data;
      logic [31:0] exp_sum;
      int          exp_max_out;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } ret_t;

   vec_t        vecs[6];
   ret_t        pend[$];
   logic [31:0] idx_log[$];
   logic [31:0] res_log[$];

   int vectors = 0, miscompares = 0;
   int cyc = 0, lat = 2, exp_out = 0, max_out = 0, out_bad = 0, sd_cnt = 0;
   int stall_hit = 0, hold_bad = 0, busy_left = 0, busy_seen = 0, spur = 0;
   bit busy_arm = 1'b0, rdy_en = 1'b0, prev_hold = 1'b0;
   logic [31:0] prev_idx = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Callee, consumer and monitors; drives DUT inputs on the falling edge.
   always @(negedge clock) begin
      bit from_q, ret, call;
      cyc++;
      if (!resetn) begin
         exp_out   = 0;
         comp_done = 1'b0;
         comp_busy = 1'b0;
         res_ready = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (int'(outstanding) != exp_out) out_bad++;
         if (int'(outstanding) > max_out) max_out = int'(outstanding);
         if (sweep_done) sd_cnt++;
         if (prev_hold && (!comp_start || comp_idx != prev_idx)) hold_bad++;
         if (busy_arm && busy_left == 0 && idx_log.size() == 1 && comp_start) begin
            busy_left = 5;
            busy_arm  = 1'b0;
         end
         comp_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
         from_q = 1'b0;
         if (spur > 0) begin
            comp_done = 1'b1;
            comp_returndata = 32'h1234;
            spur--;
         end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            comp_done = 1'b1;
            comp_returndata = pend[0].data;
            from_q = 1'b1;
         end else begin
            comp_done = 1'b0;
            comp_returndata = '0;
         end
         if (comp_done && comp_stall) stall_hit++;
         ret = comp_done && !comp_stall;
         if (ret && from_q) void'(pend.pop_front());
         if (ret && exp_out > 0) exp_out--;
         call = comp_start && !comp_busy;
         if (call) begin
            pend.push_back('{cyc + lat, comp_idx << 1});
            idx_log.push_back(comp_idx);
            exp_out++;
         end
         if (comp_busy && comp_start) busy_seen++;
         prev_hold = comp_busy && comp_start;
         prev_idx  = comp_idx;
         res_ready = rdy_en;
         if (res_valid && res_ready) res_log.push_back(res_data);
      end
   end

   task automatic clear_logs();
      idx_log.delete();
      res_log.delete();
      sd_cnt = 0; max_out = 0; out_bad = 0; stall_hit = 0; hold_bad = 0; busy_seen = 0;
   endtask

   task automatic issue_cmd(input logic [31:0] base, input int count, input int l);
      lat       = l;
      cmd_valid = 1'b1;
      cmd_base  = base;
      cmd_count = CNT_W'(count);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_sweep(input string name, input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (sd_cnt >= 1 && res_log.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({name, "_finished"}, 64'(ok), 64'(1));
      repeat (3) tick();
   endtask

   task automatic check_results(input string name, input logic [31:0] base, input int n);
      check({name, "_nresults"}, 64'(res_log.size()), 64'(n));
      for (int i = 0; i < res_log.size() && i < n; i++) begin
         logic [31:0] e;
         e = (base + 32'(i)) << 1;
         check({name, "_res_data"}, 64'(res_log[i]), 64'(e));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_comp_start"}, 64'(comp_start), 64'(0));
      check({tag, "_comp_idx"}, 64'(comp_idx), 64'(0));
      check({tag, "_comp_stall"}, 64'(comp_stall), 64'(0));
      check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
      check({tag, "_sweep_done"}, 64'(sweep_done), 64'(0));
      check({tag, "_outstanding"}, 64'(outstanding), 64'(0));
      check({tag, "_checksum"}, 64'(checksum), 64'(0));
      check({tag, "_err"}, 64'(err_unexpected), 64'(0));
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'd10,         3, 2, 3, 32'd10,         32'd12,     32'd20,         32'd24,         32'd66,         0};
      vecs[1] = '{32'd5,          1, 1, 1, 32'd5,          32'd5,      32'd10,         32'd10,         32'd10,         0};
      vecs[2] = '{32'd100,        6, 10, 6, 32'd100,       32'd105,    32'd200,        32'd210,        32'd1230,       4};
      vecs[3] = '{32'hFFFF_FFFE,  3, 3, 3, 32'hFFFF_FFFE,  32'h0,      32'hFFFF_FFFC,  32'h0,          32'hFFFF_FFFA,  0};
      vecs[4] = '{32'd7,          0, 2, 0, 32'd0,          32'd0,      32'd0,          32'd0,          32'd0,          0};
      vecs[5] = '{32'h1000,       9, 1, 9, 32'h1000,       32'h1008,   32'h2000,       32'h2010,       32'h12048,      0};

      repeat (3) tick();
      check_reset_outputs("por");
      resetn = 1'b1;
      rdy_en = 1'b1;
      tick();

      foreach (vecs[k]) begin
         clear_logs();
         issue_cmd(vecs[k].base, vecs[k].count, vecs[k].lat);
         wait_sweep("sweep", vecs[k].exp_calls);
         check("sweep_calls", 64'(idx_log.size()), 64'(vecs[k].exp_calls));
         check_results("sweep", vecs[k].base, vecs[k].exp_calls);
         if (vecs[k].exp_calls > 0 && idx_log.size() > 0 && res_log.size() > 0) begin
            check("first_idx", 64'(idx_log[0]), 64'(vecs[k].exp_first_idx));
            check("last_idx", 64'(idx_log[idx_log.size()-1]), 64'(vecs[k].exp_last_idx));
            check("first_data", 64'(res_log[0]), 64'(vecs[k].exp_first_data));
            check("last_data", 64'(res_log[res_log.size()-1]), 64'(vecs[k].exp_last_data));
         end
         check("sweep_done_pulses", 64'(sd_cnt), 64'(1));
         check("checksum", 64'(checksum), 64'(CK ? vecs[k].exp_sum : 32'd0));
         check("outstanding_track", 64'(out_bad), 64'(0));
         check("max_outstanding_le", 64'(max_out <= MAX_OUT), 64'(1));
         if (vecs[k].exp_max_out > 0)
            check("max_outstanding", 64'(max_out), 64'(vecs[k].exp_max_out));
         check("no_err", 64'(err_unexpected), 64'(0));
      end

      // Zero count: pulse lands in the cycle right after the accepting edge, no calls.
      clear_logs();
      issue_cmd(32'd3, 0, 2);
      check("zero_sweep_done_hi", 64'(sweep_done), 64'(1));
      check("zero_cmd_ready_lo", 64'(cmd_ready), 64'(0));
      tick();
      check("zero_sweep_done_lo", 64'(sweep_done), 64'(0));
      check("zero_cmd_ready_hi", 64'(cmd_ready), 64'(1));
      repeat (3) tick();
      check("zero_calls", 64'(idx_log.size()), 64'(0));
      check("zero_pulses", 64'(sd_cnt), 64'(1));

      // Callee busy during the second call.
      clear_logs();
      busy_arm = 1'b1;
      issue_cmd(32'd20, 4, 2);
      wait_sweep("busy", 4);
      check("busy_calls", 64'(idx_log.size()), 64'(4));
      for (int i = 0; i < idx_log.size() && i < 4; i++)
         check("busy_idx", 64'(idx_log[i]), 64'(20 + i));
      check("busy_cycles", 64'(busy_seen), 64'(5));
      check("busy_hold", 64'(hold_bad), 64'(0));
      check_results("busy", 32'd20, 4);

      // Result backpressure: FIFO fills, calls stop at FIFO_DEPTH without stalling a return.
      clear_logs();
      rdy_en = 1'b0;
      issue_cmd(32'd50, 12, 2);
      repeat (40) tick();
      check("bp_calls", 64'(idx_log.size()), 64'(FIFO_DEPTH));
      check("bp_res_valid", 64'(res_valid), 64'(1));
      check("bp_outstanding", 64'(outstanding), 64'(0));
      check("bp_comp_start", 64'(comp_start), 64'(0));
      check("bp_nothing_popped", 64'(res_log.size()), 64'(0));
      rdy_en = 1'b1;
      wait_sweep("bp", 12);
      check("bp_stall_hit", 64'(stall_hit), 64'(0));
      check("bp_total_calls", 64'(idx_log.size()), 64'(12));
      check_results("bp", 32'd50, 12);
      check("bp_pulses", 64'(sd_cnt), 64'(1));
      check("bp_checksum", 64'(checksum), 64'(CK ? 32'd1332 : 32'd0));

      // Reset in the middle of a sweep with two calls in flight.
      clear_logs();
      issue_cmd(32'd0, 10, 10);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 50; i++) begin
            if (outstanding == OW'(2)) begin
               seen = 1'b1;
               break;
            end
            tick();
         end
         check("rst_reached_two", 64'(seen), 64'(1));
      end
      resetn = 1'b0;
      tick();
      pend.delete();
      out_bad = 0;
      check_reset_outputs("midrst");
      resetn = 1'b1;
      tick();
      spur = 1;
      tick();
      tick();
      check("spur_err", 64'(err_unexpected), 64'(1));
      check("spur_no_push", 64'(res_valid), 64'(0));
      check("spur_outstanding", 64'(outstanding), 64'(0));
      check("spur_track", 64'(out_bad), 64'(0));
      repeat (3) tick();
      check("spur_err_sticky", 64'(err_unexpected), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
